// File: rtl/wb_register_file_pkg.sv
// Shared constants and types for the integer register file, decode and write-back.
package wb_register_file_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [ADDR_WIDTH-1:0] reg_index_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH:0]   busy_cnt_t;

    localparam reg_index_t REG_ZERO = '0;

    function automatic busy_cnt_t popcount(input logic [REG_COUNT-1:0] v);
        busy_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < REG_COUNT; i++) cnt = cnt + busy_cnt_t'(v[i]);
        return cnt;
    endfunction
endpackage

// File: rtl/wb_register_file_if.sv
// Decode read/issue, write-back and stall signals of the register file.
interface wb_register_file_if;
    import wb_register_file_pkg::*;

    reg_index_t RS1_ADDR;
    reg_index_t RS2_ADDR;
    logic       RS1_USED;
    logic       RS2_USED;
    word_t      RS1_DATA;
    word_t      RS2_DATA;
    logic       ISSUE_VALID;
    reg_index_t ISSUE_RD_ADDR;
    logic       ISSUE_RD_EN;
    logic       WB_WRITE_EN;
    reg_index_t WB_RD_ADDR;
    word_t      WB_DATA;
    logic       HAZARD;
    busy_cnt_t  BUSY_COUNT;

    modport master (
        output RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED,
        output ISSUE_VALID, ISSUE_RD_ADDR, ISSUE_RD_EN,
        output WB_WRITE_EN, WB_RD_ADDR, WB_DATA,
        input  RS1_DATA, RS2_DATA, HAZARD, BUSY_COUNT
    );

    modport slave (
        input  RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED,
        input  ISSUE_VALID, ISSUE_RD_ADDR, ISSUE_RD_EN,
        input  WB_WRITE_EN, WB_RD_ADDR, WB_DATA,
        output RS1_DATA, RS2_DATA, HAZARD, BUSY_COUNT
    );
endinterface

// File: rtl/wb_register_file_scoreboard.sv
// Per-register busy bits with set-over-clear priority, busy count and operand pending lookup.
module wb_scoreboard
    import wb_register_file_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_set_en,
    input  reg_index_t i_set_addr,
    input  logic       i_clr_en,
    input  reg_index_t i_clr_addr,
    input  reg_index_t i_rs1_addr,
    input  reg_index_t i_rs2_addr,
    output logic       o_rs1_pending,
    output logic       o_rs2_pending,
    output busy_cnt_t  o_busy_count
);
    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_busy_nxt;
    busy_cnt_t            r_busy_count;

    // Clear first so an issue to the same index on this edge leaves it pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en && i_clr_addr != REG_ZERO) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set_en && i_set_addr != REG_ZERO) w_busy_nxt[i_set_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= popcount(w_busy_nxt);
        end
    end

    // A write-back landing this cycle resolves the dependency via the bypass.
    assign o_rs1_pending = r_busy[i_rs1_addr] && (i_rs1_addr != REG_ZERO) &&
                           !(i_clr_en && i_clr_addr == i_rs1_addr);
    assign o_rs2_pending = r_busy[i_rs2_addr] && (i_rs2_addr != REG_ZERO) &&
                           !(i_clr_en && i_clr_addr == i_rs2_addr);
    assign o_busy_count  = r_busy_count;
endmodule

// File: rtl/wb_register_file.sv
// 32x32 integer register file with x0 hardwired to zero, write-to-read bypass and busy-based stall.
module wb_register_file
    import wb_register_file_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    wb_register_file_if.slave bus
);
    word_t r_regs [REG_COUNT];
    word_t w_rs1_data;
    word_t w_rs2_data;
    logic  w_rs1_pending;
    logic  w_rs2_pending;
    logic  w_hazard;
    logic  w_wb_live;

    assign w_wb_live = bus.WB_WRITE_EN && (bus.WB_RD_ADDR != REG_ZERO);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (w_wb_live) begin
            r_regs[bus.WB_RD_ADDR] <= bus.WB_DATA;
        end
    end

    always_comb begin
        w_rs1_data = r_regs[bus.RS1_ADDR];
        if (bus.RS1_ADDR == REG_ZERO) w_rs1_data = '0;
        else if (w_wb_live && bus.WB_RD_ADDR == bus.RS1_ADDR) w_rs1_data = bus.WB_DATA;
    end

    always_comb begin
        w_rs2_data = r_regs[bus.RS2_ADDR];
        if (bus.RS2_ADDR == REG_ZERO) w_rs2_data = '0;
        else if (w_wb_live && bus.WB_RD_ADDR == bus.RS2_ADDR) w_rs2_data = bus.WB_DATA;
    end

    assign w_hazard = (bus.RS1_USED && w_rs1_pending) || (bus.RS2_USED && w_rs2_pending);

    wb_scoreboard u_scoreboard (
        .i_clk         (CLK),
        .i_rst_n       (RST_N),
        .i_set_en      (bus.ISSUE_VALID && bus.ISSUE_RD_EN && !w_hazard),
        .i_set_addr    (bus.ISSUE_RD_ADDR),
        .i_clr_en      (bus.WB_WRITE_EN),
        .i_clr_addr    (bus.WB_RD_ADDR),
        .i_rs1_addr    (bus.RS1_ADDR),
        .i_rs2_addr    (bus.RS2_ADDR),
        .o_rs1_pending (w_rs1_pending),
        .o_rs2_pending (w_rs2_pending),
        .o_busy_count  (bus.BUSY_COUNT)
    );

    // Reads and stall are forced quiet while reset is held.
    assign bus.RS1_DATA = RST_N ? w_rs1_data : '0;
    assign bus.RS2_DATA = RST_N ? w_rs2_data : '0;
    assign bus.HAZARD   = RST_N && w_hazard;
endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Integer register file that receives the write-back stage's selected result and serves the decode stage's two operand reads.
- Holds 32 x 32-bit architectural registers, with x0 hardwired to zero.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard: set when an instruction issues with a destination, cleared when its result is written back. Drives a HAZARD stall to decode.

Parameters:
- DATA_WIDTH, 32, register and bus width.
- ADDR_WIDTH, 5, register index width.
- REG_COUNT, 32, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- RS1_ADDR  input  ADDR_WIDTH  read port 1 index.
- RS2_ADDR  input  ADDR_WIDTH  read port 2 index.
- RS1_USED  input  1  decode needs RS1 (qualifies hazard).
- RS2_USED  input  1  decode needs RS2 (qualifies hazard).
- RS1_DATA  output  DATA_WIDTH  read port 1 data.
- RS2_DATA  output  DATA_WIDTH  read port 2 data.
- ISSUE_VALID  input  1  instruction leaving decode this cycle.
- ISSUE_RD_ADDR  input  ADDR_WIDTH  destination of issuing instruction.
- ISSUE_RD_EN  input  1  issuing instruction writes a register.
- WB_WRITE_EN  input  1  write-back valid.
- WB_RD_ADDR  input  ADDR_WIDTH  write-back destination.
- WB_DATA  input  DATA_WIDTH  write-back value (output of write-back select mux).
- HAZARD  output  1  decode must stall.
- BUSY_COUNT  output  ADDR_WIDTH+1  number of busy registers.

Behaviour:
- Reset (RST_N low at a rising edge): all registers cleared to 0, all busy bits cleared, BUSY_COUNT = 0. Inputs are ignored that cycle.
- While reset is held: RS1_DATA, RS2_DATA and HAZARD read 0.
- Reset asserted mid-operation discards pending busy state. A later write-back to a formerly busy register is still written, but does not underflow BUSY_COUNT.
- Reads are combinational. Address 0 always returns 0.
- Read bypass: if WB_WRITE_EN=1, WB_RD_ADDR equals the read address, and that address is non-zero, the port returns WB_DATA in the same cycle. Otherwise it returns the stored value.
- Writes: on a rising edge with WB_WRITE_EN=1 and WB_RD_ADDR != 0, store WB_DATA. Writes to x0 are discarded.
- Write latency: visible through the bypass in the same cycle; stored from the next cycle.
- Busy set: on a rising edge with ISSUE_VALID=1, ISSUE_RD_EN=1, ISSUE_RD_ADDR != 0 and HAZARD=0, set busy[ISSUE_RD_ADDR].
  - Issue while HAZARD=1 is ignored; decode is required not to issue.
- Busy clear: on a rising edge with WB_WRITE_EN=1 and WB_RD_ADDR != 0, clear busy[WB_RD_ADDR].
  - Write-back to a non-busy register is legal: data is written, busy is unchanged.
- Simultaneous set and clear of the same index: set wins. The new producer is pending and the old result is written.
- HAZARD = (RS1_USED & rs1_pending) | (RS2_USED & rs2_pending).
  - rsN_pending = busy[RSN_ADDR] & RSN_ADDR != 0 & ~(WB_WRITE_EN & WB_RD_ADDR == RSN_ADDR). A same-cycle write-back resolves the hazard through the bypass.
- HAZARD is combinational; no registered stall.
- BUSY_COUNT = popcount(busy), registered, updated on the same edge as busy. Range 0..31; cannot wrap because x0 is never busy.
- No X propagation: unused register contents are always defined after reset.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, ADDR_WIDTH, REG_COUNT constants.
  - REG_ZERO = 0 constant.
  - reg_index_t and word_t typedefs, reused by decode and write-back.
- One natural sub-module: wb_scoreboard. It contains the busy vector, set/clear priority, BUSY_COUNT and pending lookup for two read addresses.
- Storage array and bypass stay in the top.

Test Plan:
- Reset then read x5 and x0 -> both 0, HAZARD=0, BUSY_COUNT=0.
- Write 0xDEADBEEF to x7 with RS1_ADDR=7 in the same cycle -> RS1_DATA=0xDEADBEEF that cycle. Next cycle, with WB_WRITE_EN=0, still 0xDEADBEEF.
- Write 0x12345678 to x0 -> RS1_ADDR=0 reads 0 on the same and next cycle.
- Issue rd=3; next cycle RS2_ADDR=3, RS2_USED=1 -> HAZARD=1, BUSY_COUNT=1.
  - Write-back x3=0x55 -> HAZARD=0 that cycle, RS2_DATA=0x55, BUSY_COUNT=0 next cycle.
  - Same with RS2_USED=0 -> HAZARD=0.
- Same edge: issue rd=4 and write-back x4=0xAA -> x4 stores 0xAA and stays busy, BUSY_COUNT=1.
- Issue rd=9, then assert RST_N=0 for one cycle -> busy cleared, x9 reads 0, BUSY_COUNT=0. Later write-back to x9 stores the value and BUSY_COUNT stays 0.
